conv3_relu_pool: RTL and testbench
==================================

# conv3_relu_pool

Receiver-side stage for the layer-3 accumulator output stream. Consumes the raster-ordered WIDTH×HEIGHT burst of filter_num-lane IEEE-754 single-precision pixel vectors emitted after channel accumulation. Applies ReLU and 2×2/stride-2 max pooling per lane, then emits (WIDTH/2)×(HEIGHT/2) pooled vectors to the next layer. No backpressure: the upstream producer cannot stall, so this block must accept one beat per cycle indefinitely.

## Interface
- WIDTH, 6, frame width in pixels; must be even.
- HEIGHT, 8, frame height in pixels; must be even.
- filter_num, 128, number of 32-bit lanes per beat.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  data_in carries one pixel vector this cycle.
- data_in  in  32×filter_num  unpacked array [0:filter_num-1], FP32 per lane.
- valid_out  out  1  data_out carries one pooled vector this cycle.
- data_out  out  32×filter_num  unpacked array, pooled FP32 per lane.
- out_idx  out  $clog2(WIDTH*HEIGHT/4)  raster index of the pooled pixel on data_out.
- frame_done  out  1  one-cycle pulse with the last pooled beat of a frame.

## Operation
- Input order: w fastest (0..WIDTH-1), then h (0..HEIGHT-1); one frame = WIDTH*HEIGHT valid beats. Gaps (valid_in=0) allowed anywhere; counters and storage hold.
- ReLU per lane: r = data_in[31] ? 32'h0 : data_in. Covers -0.0 (32'h80000000) -> +0.0.
- After ReLU all values are sign-0, so max = unsigned 32-bit compare; no FP unit. Positive NaN/Inf compare as largest encodings and pass through unchanged.
- Counters w_idx, h_idx advance on each valid beat; wrap w at WIDTH-1, h at HEIGHT-1 (frame wraps to (0,0), next frame starts immediately).
- Even w: hmax[lane] <= r.
- Odd w: pair = max(hmax, r).
  - Even h: row_buf[w>>1][lane] <= pair.
  - Odd h: data_out[lane] <= max(row_buf[w>>1][lane], pair); valid_out <= 1; out_idx <= (h>>1)*(WIDTH/2) + (w>>1).
- frame_done <= 1 on the beat that produces out_idx = WIDTH*HEIGHT/4-1.
- No FSM beyond the (w_idx, h_idx) position counter; row_buf is WIDTH/2 entries × filter_num × 32 bits, hmax is filter_num × 32 bits.

## Timing
- Reset (asynchronous): valid_out=0, frame_done=0, out_idx=0, data_out all 0, w_idx=h_idx=0, hmax and row_buf all 0.
- Latency: valid_out asserts exactly 1 cycle after the input beat at (odd w, odd h). One pooled beat per two input beats on odd rows, none on even rows.
- valid_out and frame_done are single-cycle pulses. data_out and out_idx hold their last value while valid_out=0.
- Back-to-back frames: last beat of frame N and first beat of frame N+1 on consecutive cycles must both be accepted; frame_done for N coincides with no loss of frame N+1 data.
- Reset mid-frame: position returns to (0,0); partial window discarded; next valid beat is treated as pixel (0,0).

## Structure
- Shared package conv3_pkg: WIDTH/HEIGHT/filter_num defaults, FP32 typedef, relu function, unsigned max function, -0.0 constant.
- Top owns counters, out_idx, valid_out, frame_done.
- Sub-module pool_lane (one instance per lane via generate): holds hmax and the lane's WIDTH/2 row_buf slice, inputs r, w parity, h parity, col index; outputs pooled value.

## Test plan
- Single frame, all lanes pixel (w,h) = 1.0 (32'h3F800000) except (1,1)=2.0 (32'h40000000): 12 output beats, out_idx 0..11, beat 0 = 32'h40000000, others 32'h3F800000; frame_done with out_idx=11.
- All inputs -1.0 (32'hBF800000) or 32'h80000000: all 12 outputs 32'h00000000.
- Window (0,0),(1,0),(0,1),(1,1) = 0.5, -3.0, 0.25, 0.75: out_idx 0 = 32'h3F400000 (0.75); verify max taken across row pair, not just within row.
- Random valid_in gaps (50% duty) over one frame: outputs identical to gapless run; valid_out exactly 1 cycle after each (odd w, odd h) beat.
- Two frames back-to-back with distinct data: 24 outputs, second frame's out_idx restarts at 0, two frame_done pulses.
- Assert rst_n low after 20 beats, release, send full frame: only 12 outputs from the new frame, correct values, all outputs 0 during reset.

Source files
------------

// File: rtl/conv3_pkg.sv
// conv3_pkg: shared types, defaults and helpers for the layer-3
// ReLU + 2x2 max-pool stage.
package conv3_pkg;

    localparam int DEF_WIDTH      = 6;
    localparam int DEF_HEIGHT     = 8;
    localparam int DEF_FILTER_NUM = 128;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_NEG_ZERO = 32'h8000_0000;

    // Any sign-set encoding, including -0.0, clamps to +0.0.
    function automatic fp32_t relu(input fp32_t x);
        return x[31] ? '0 : x;
    endfunction

    // Sign bits are clear after relu, so integer order equals FP order.
    function automatic fp32_t umax(input fp32_t a, input fp32_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv3_relu_pool_pool_lane.sv
// pool_lane: one lane of the 2x2 max pool; holds the horizontal pair
// maximum and this lane's slice of the even-row buffer.
module pool_lane
    import conv3_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  fp32_t         r,
    input  logic          w_odd,
    input  logic          h_odd,
    input  logic [CW-1:0] col,
    output fp32_t         pooled
);

    fp32_t hmax;
    fp32_t pair;
    fp32_t row_buf [0:WIDTH/2-1];

    assign pair = umax(hmax, r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hmax   <= '0;
            pooled <= '0;
            for (int i = 0; i < WIDTH / 2; i++) begin
                row_buf[i] <= '0;
            end
        end else if (en) begin
            if (!w_odd) begin
                hmax <= r;
            end else if (!h_odd) begin
                row_buf[col] <= pair;
            end else begin
                pooled <= umax(row_buf[col], pair);
            end
        end
    end

endmodule

// File: rtl/conv3_relu_pool.sv
// conv3_relu_pool: ReLU then 2x2/stride-2 max pool over a raster
// stream of filter_num-lane FP32 vectors, one beat per cycle.
module conv3_relu_pool
    import conv3_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int filter_num = DEF_FILTER_NUM,
    localparam int OW        = $clog2(WIDTH * HEIGHT / 4)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  fp32_t         data_in  [0:filter_num-1],
    output logic          valid_out,
    output fp32_t         data_out [0:filter_num-1],
    output logic [OW-1:0] out_idx,
    output logic          frame_done
);

    localparam int WW   = $clog2(WIDTH);
    localparam int HW   = $clog2(HEIGHT);
    localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
    localparam int LAST = WIDTH * HEIGHT / 4 - 1;

    logic [WW-1:0] w_idx;
    logic [HW-1:0] h_idx;
    logic [CW-1:0] col;
    logic [OW-1:0] pos;
    logic          fire;

    assign fire = valid_in & w_idx[0] & h_idx[0];
    assign col  = CW'(w_idx >> 1);
    assign pos  = OW'(int'(h_idx >> 1) * (WIDTH / 2) + int'(col));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_idx <= '0;
            h_idx <= '0;
        end else if (valid_in) begin
            if (w_idx == WW'(WIDTH - 1)) begin
                w_idx <= '0;
                h_idx <= (h_idx == HW'(HEIGHT - 1)) ? '0 : h_idx + 1'b1;
            end else begin
                w_idx <= w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            out_idx    <= '0;
        end else begin
            valid_out  <= fire;
            frame_done <= fire && (pos == OW'(LAST));
            if (fire) begin
                out_idx <= pos;
            end
        end
    end

    for (genvar i = 0; i < filter_num; i++) begin : g_lane
        pool_lane #(
            .WIDTH(WIDTH),
            .CW   (CW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (valid_in),
            .r     (relu(data_in[i])),
            .w_odd (w_idx[0]),
            .h_odd (h_idx[0]),
            .col   (col),
            .pooled(data_out[i])
        );
    end

endmodule

// File: tb/tb_conv3_relu_pool.sv
// tb_conv3_relu_pool: randomized stimulus, window-max reference model
// and a queue scoreboard drained by an output monitor.
module tb_conv3_relu_pool;

    localparam int W    = 6;
    localparam int H    = 8;
    localparam int FN   = 128;
    localparam int OW   = $clog2(W * H / 4);
    localparam int NOUT = W * H / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [31:0]   data_in  [0:FN-1];
    logic          valid_out;
    logic [31:0]   data_out [0:FN-1];
    logic [OW-1:0] out_idx;
    logic          frame_done;

    conv3_relu_pool #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .filter_num(FN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .out_idx   (out_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;
    int n_done = 0;

    int          q_cyc  [$];
    int          q_idx  [$];
    bit          q_done [$];
    logic [31:0] q_dat  [$];

    logic [31:0] pix [0:H-1][0:W-1][0:FN-1];
    logic [31:0] rnd [0:H-1][0:W-1][0:FN-1];
    logic [31:0] exp_buf [0:FN-1];
    int pw = 0;
    int ph = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] pattern(input int mode, input int w,
                                            input int h, input int l);
        logic [31:0] v;
        v = rnd[h][w][l];
        if (mode == 0) begin
            v = (w == 1 && h == 1) ? 32'h4000_0000 : 32'h3F80_0000;
        end else if (mode == 1) begin
            v = ((w + h + l) % 2 == 1) ? 32'hBF80_0000 : 32'h8000_0000;
        end else if (mode == 2) begin
            if (w == 0 && h == 0) v = 32'h3F00_0000;
            if (w == 1 && h == 0) v = 32'hC040_0000;
            if (w == 0 && h == 1) v = 32'h3E80_0000;
            if (w == 1 && h == 1) v = 32'h3F40_0000;
        end
        return v;
    endfunction

    task automatic fill_rnd();
        for (int h = 0; h < H; h++)
            for (int w = 0; w < W; w++)
                for (int l = 0; l < FN; l++)
                    rnd[h][w][l] = ($urandom_range(0, 15) == 0) ?
                                   32'h7FC0_0000 : $urandom;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int l = 0; l < FN; l++) data_in[l] = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int mode);
        logic [31:0] v;
        logic [31:0] m;
        int          idx;
        for (int l = 0; l < FN; l++) begin
            v = pattern(mode, pw, ph, l);
            data_in[l] = v;
            pix[ph][pw][l] = v[31] ? 32'h0 : v;
        end
        if (pw % 2 == 1 && ph % 2 == 1) begin
            idx = (ph / 2) * (W / 2) + pw / 2;
            q_cyc.push_back(cyc + 1);
            q_idx.push_back(idx);
            q_done.push_back(idx == NOUT - 1);
            for (int l = 0; l < FN; l++) begin
                m = 32'h0;
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if (pix[ph-1+dy][pw-1+dx][l] > m)
                            m = pix[ph-1+dy][pw-1+dx][l];
                q_dat.push_back(m);
            end
        end
        pw++;
        if (pw == W) begin
            pw = 0;
            ph = (ph + 1) % H;
        end
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic frame(input int mode, input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            if (gaps) while ($urandom_range(0, 1) == 1) idle(1);
            beat(mode);
        end
    endtask

    task automatic reset_checks(input string tag);
        int bad;
        bad = 0;
        for (int l = FN - 1; l >= 0; l--)
            if (data_out[l] !== 32'h0) bad = l;
        chk({tag, "_valid_out"}, 32'(valid_out), 32'h0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_out_idx"}, 32'(out_idx), 32'h0);
        chk($sformatf("%s_data_out[%0d]", tag, bad), data_out[bad], 32'h0);
    endtask

    task automatic count_check(input string tag, input int o0, input int d0,
                               input int nf);
        chk({tag, "_outputs"}, n_out - o0, nf * NOUT);
        chk({tag, "_frame_done_pulses"}, n_done - d0, nf);
    endtask

    always @(negedge clk) begin
        int bad;
        if (rst_n === 1'b1) begin
            if (valid_out) begin
                n_out++;
                if (frame_done) n_done++;
                if (q_cyc.size() == 0) begin
                    chk("unexpected_valid_out_pending", q_cyc.size(), 1);
                end else begin
                    chk("latency_cycle", cyc, q_cyc.pop_front());
                    chk("out_idx", 32'(out_idx), q_idx.pop_front());
                    chk("frame_done", 32'(frame_done), 32'(q_done.pop_front()));
                    bad = 0;
                    for (int l = 0; l < FN; l++) exp_buf[l] = q_dat.pop_front();
                    for (int l = FN - 1; l >= 0; l--)
                        if (data_out[l] !== exp_buf[l]) bad = l;
                    chk($sformatf("data_out[%0d] idx %0d", bad, out_idx),
                        data_out[bad], exp_buf[bad]);
                end
            end else begin
                if (frame_done) chk("frame_done_without_valid", 32'(valid_out), 32'(frame_done));
                if (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                    chk($sformatf("valid_out_at_cycle_%0d", q_cyc[0]), 32'(valid_out), 32'h1);
                    void'(q_cyc.pop_front());
                    void'(q_idx.pop_front());
                    void'(q_done.pop_front());
                    for (int l = 0; l < FN; l++) void'(q_dat.pop_front());
                end
            end
        end
    end

    initial begin
        int o0;
        int d0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        for (int l = 0; l < FN; l++) data_in[l] = '0;
        fill_rnd();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        rst_n = 1'b1;
        idle(1);

        o0 = n_out; d0 = n_done;
        frame(0, 1'b0);
        idle(3);
        count_check("ones_frame", o0, d0, 1);

        o0 = n_out; d0 = n_done;
        frame(1, 1'b0);
        idle(3);
        count_check("negative_frame", o0, d0, 1);

        fill_rnd();
        o0 = n_out; d0 = n_done;
        frame(2, 1'b0);
        idle(3);
        count_check("window_frame", o0, d0, 1);

        fill_rnd();
        frame(3, 1'b0);
        idle(2);
        o0 = n_out; d0 = n_done;
        frame(3, 1'b1);
        idle(3);
        count_check("gapped_frame", o0, d0, 1);

        fill_rnd();
        o0 = n_out; d0 = n_done;
        frame(3, 1'b0);
        frame(0, 1'b0);
        idle(3);
        count_check("back_to_back", o0, d0, 2);

        fill_rnd();
        for (int i = 0; i < 20; i++) beat(3);
        idle(2);
        chk("drained_before_reset", q_cyc.size(), 0);
        rst_n = 1'b0;
        #1;
        reset_checks("mid_reset");
        pw = 0;
        ph = 0;
        idle(2);
        reset_checks("held_reset");
        rst_n = 1'b1;
        fill_rnd();
        o0 = n_out; d0 = n_done;
        frame(3, 1'b0);
        idle(3);
        count_check("after_reset", o0, d0, 1);

        chk("scoreboard_empty", q_cyc.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
